nabp_pe_accumulator: RTL and testbench
======================================

# nabp_pe_accumulator

- Backprojection processing element for one partition.
- Consumes one tap stream from the swappable processing stage's line buffer, framed by `sw_pe_kick`.
- Accumulates `pSize` pixel sums over `pNoOfAngles` angle passes, then drains the finished pixel line to the image writer with a valid/ready handshake.
- One instance per partition, fed by one `pDataLength` slice of `pe_taps`.

## Interface
- `pDataLength`, 16: width of a signed filtered tap (`kFilteredDataLength`).
- `pAccuLength`, 24: width of a signed accumulator entry; must be ≥ `pDataLength`.
- `pSize`, 32: pixels per partition line (entries in the buffer).
- `pNoOfAngles`, 180: angle passes per line before drain.
- `pPtrLength`, 5: pointer width, equal to `bin_width(pSize)`.
- `pAngleLength`, 8: angle counter width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `sw_pe_kick` in 1: one-cycle pulse marking the start of an angle pass.
- `tap_valid` in 1: `tap` carries the next pixel contribution this cycle.
- `tap` in `pDataLength`, signed: filtered value for the current pixel.
- `out_ready` in 1: downstream accepts a drained pixel.
- `out_valid` out 1: drained pixel available.
- `out_addr` out `pPtrLength`: pixel index of `out_val`.
- `out_val` out `pAccuLength`, signed: accumulated pixel sum.
- `line_done` out 1: one-cycle pulse on the final drain handshake.
- `busy` out 1: high in CLEAR.
- `err_kick_overrun` out 1: sticky; set by a kick that arrives outside WAIT.

## Operation
- States are CLEAR, WAIT, ACCU and DRAIN. Internal registers are `ptr` (`pPtrLength`), `angle` (`pAngleLength`) and the `pSize`×`pAccuLength` register array.
- **CLEAR:** entered on reset.
  - Writes 0 to `mem[ptr]` each cycle, `ptr` 0→`pSize-1`.
  - After the last write: go to WAIT with `ptr`=0 and `angle`=0.
- **WAIT:** on `sw_pe_kick` go to ACCU with `ptr`=0. `tap_valid` is ignored in this state.
- **ACCU:** each cycle with `tap_valid`:
  - Compute `mem[ptr]` + sign-extended `tap`, saturated to [-2^(A-1), 2^(A-1)-1], and write it back to `mem[ptr]`.
  - Increment `ptr`.
  - When `ptr`=`pSize-1` is written: reset `ptr` to 0.
    - If `angle`=`pNoOfAngles-1`, go to DRAIN.
    - Otherwise increment `angle` and go to WAIT.
- **DRAIN:**
  - Outputs: `out_valid`=1, `out_addr`=`ptr`, `out_val`=`mem[ptr]`.
  - On handshake (`out_valid` & `out_ready`): write 0 to `mem[ptr]` (clear-on-read) and increment `ptr`.
  - On the last handshake: pulse `line_done`, set `ptr`=0 and `angle`=0, go to WAIT.
- **Kick outside WAIT** (CLEAR, ACCU or DRAIN): the kick is ignored, `err_kick_overrun` is set, and the current state, `ptr` and accumulation are unaffected.
- **Taps outside ACCU** are discarded.

## Timing
- Reset values:
  - `out_valid`=0, `out_addr`=0, `out_val`=0 (`out_val` is forced to 0 whenever `out_valid`=0).
  - `line_done`=0, `err_kick_overrun`=0.
  - `busy`=1, because reset enters CLEAR.
- CLEAR lasts `pSize` cycles after reset deasserts, and `busy` falls in the cycle WAIT is entered.
- A kick in cycle n puts the block in ACCU at n+1; the first tap is accepted at n+1 at the earliest. A tap presented with the kick in cycle n is not accumulated.
- Accumulate is single-cycle read-modify-write with combinational read of `mem[ptr]` and a registered write, so back-to-back taps are supported.
- `out_valid` rises the cycle after the final tap of the last angle pass.
- `out_val`/`out_addr` hold stable while `out_ready`=0. Full throughput is 1 pixel/cycle.
- `line_done` is asserted in the same cycle as the final handshake. WAIT is entered the next cycle, and a kick in that cycle is accepted.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), CLEAR re-runs, and partial sums are lost.

## Structure
- Shared package holds:
  - the `tPEState` enum;
  - the saturating-add width rule (sign-extend, then clamp);
  - `kFilteredDataLength` and `kNoOfPartitions` (already global).
- One sub-module, `nabp_pe_accu_buffer`:
  - `pSize`-entry register array with combinational read;
  - one write port with a write-enable;
  - no reset on the array contents, because CLEAR zeroes them.
- The top level holds the FSM, counters and saturation logic.

## Test plan
Bench parameters unless stated: `pSize`=4, `pNoOfAngles`=2, `pDataLength`=8, `pAccuLength`=10.
1. Reset release → `busy`=1 for exactly 4 cycles, then 0; `out_valid`=0; `err_kick_overrun`=0.
2. Two angle passes:
   - Stimulus: kick, taps 1,2,3,4; then kick, taps 10,20,30,40; `out_ready`=1.
   - Required: `out_val` 11,22,33,44 at addr 0..3 on 4 consecutive cycles, `line_done` on the 4th.
   - Next line: taps 1,1,1,1 twice → 2,2,2,2 (buffer was cleared on read).
3. Saturation, with `pAccuLength`=8: taps 127 twice → 127; taps -128 twice → -128.
4. Backpressure: `out_ready` pattern 1,0,0,1,1,0,1 → outputs 0..3 each delivered once, in order, held stable while `out_ready`=0.
5. Kick overrun: kick issued after the 2nd tap of pass 1 → `err_kick_overrun`=1 (sticky), sums unaffected, final drain matches test 2.
6. Reset mid-pass: `reset` pulse during pass 2 → outputs reset immediately, CLEAR takes 4 cycles, then a fresh line of taps 5,5,5,5 twice drains as 10,10,10,10.

Source files
------------

// File: rtl/nabp_pe_accumulator_pkg.sv
// Shared definitions for the backprojection PE accumulator: state encoding,
// global widths and the saturating-add rule used when folding a tap into a pixel sum.
package nabp_pe_accumulator_pkg;

  localparam int unsigned kFilteredDataLength = 16;
  localparam int unsigned kNoOfPartitions     = 8;

  typedef enum logic [1:0] {
    StClear,
    StWait,
    StAccu,
    StDrain
  } tPEState;

  // Operands arrive already sign-extended to 64 bits; result is clamped to an
  // acc_len-bit signed range so the caller can simply truncate.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] tap,
                                                 input int unsigned       acc_len);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = acc + tap;
    hi  = (64'sd1 <<< (acc_len - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/nabp_pe_accumulator_if.sv
// Tap stream in and drained-pixel stream out of one PE accumulator partition.
interface nabp_pe_accumulator_if #(
  parameter int unsigned pDataLength = 16,
  parameter int unsigned pAccuLength = 24,
  parameter int unsigned pPtrLength  = 5
);
  logic                          sw_pe_kick;
  logic                          tap_valid;
  logic signed [pDataLength-1:0] tap;
  logic                          out_ready;
  logic                          out_valid;
  logic [pPtrLength-1:0]         out_addr;
  logic signed [pAccuLength-1:0] out_val;
  logic                          line_done;

  modport master (
    output sw_pe_kick, tap_valid, tap, out_ready,
    input  out_valid, out_addr, out_val, line_done
  );

  modport slave (
    input  sw_pe_kick, tap_valid, tap, out_ready,
    output out_valid, out_addr, out_val, line_done
  );
endinterface

// File: rtl/nabp_pe_accu_buffer.sv
// Pixel-sum register array: combinational read, single registered write port.
// Contents are not reset; the CLEAR pass zeroes them.
module nabp_pe_accu_buffer #(
  parameter int unsigned pSize       = 32,
  parameter int unsigned pAccuLength = 24,
  parameter int unsigned pPtrLength  = 5
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [pPtrLength-1:0]         addr,
  input  logic signed [pAccuLength-1:0] wdata,
  output logic signed [pAccuLength-1:0] rdata
);

  logic signed [pAccuLength-1:0] mem [pSize];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/nabp_pe_accumulator.sv
// Backprojection PE for one partition: clears its line buffer, accumulates
// pNoOfAngles tap passes with saturation, then drains the line with clear-on-read.
module nabp_pe_accumulator
  import nabp_pe_accumulator_pkg::*;
#(
  parameter int unsigned pDataLength  = kFilteredDataLength,
  parameter int unsigned pAccuLength  = 24,
  parameter int unsigned pSize        = 32,
  parameter int unsigned pNoOfAngles  = 180,
  parameter int unsigned pPtrLength   = 5,
  parameter int unsigned pAngleLength = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  nabp_pe_accumulator_if.slave   bus,
  output logic                   busy,
  output logic                   err_kick_overrun
);

  localparam logic [pPtrLength-1:0]   kPtrLast   = pPtrLength'(pSize - 1);
  localparam logic [pAngleLength-1:0] kAngleLast = pAngleLength'(pNoOfAngles - 1);

  tPEState                       state_q, state_d;
  logic [pPtrLength-1:0]         ptr_q, ptr_d, ptr_inc;
  logic [pAngleLength-1:0]       angle_q, angle_d;
  logic                          err_q, err_d;
  logic                          ptr_last;
  logic                          mem_we;
  logic signed [pAccuLength-1:0] mem_wdata, mem_rdata, accu_sum;
  logic signed [pDataLength-1:0] tap_in;

  nabp_pe_accu_buffer #(
    .pSize      (pSize),
    .pAccuLength(pAccuLength),
    .pPtrLength (pPtrLength)
  ) u_buffer (
    .clk  (clk),
    .we   (mem_we),
    .addr (ptr_q),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign tap_in   = bus.tap;
  assign ptr_last = (ptr_q == kPtrLast);
  assign ptr_inc  = ptr_q + pPtrLength'(1);
  assign accu_sum = pAccuLength'(sat_add(64'(mem_rdata), 64'(tap_in), pAccuLength));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    angle_d   = angle_q;
    // A kick is only meaningful in WAIT; anywhere else it is flagged and dropped.
    err_d     = err_q | (bus.sw_pe_kick & (state_q != StWait));
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        if (ptr_last) begin
          state_d = StWait;
          ptr_d   = '0;
          angle_d = '0;
        end else begin
          ptr_d = ptr_inc;
        end
      end
      StWait: begin
        if (bus.sw_pe_kick) begin
          state_d = StAccu;
          ptr_d   = '0;
        end
      end
      StAccu: begin
        if (bus.tap_valid) begin
          mem_we    = 1'b1;
          mem_wdata = accu_sum;
          if (ptr_last) begin
            ptr_d = '0;
            if (angle_q == kAngleLast) begin
              state_d = StDrain;
            end else begin
              angle_d = angle_q + pAngleLength'(1);
              state_d = StWait;
            end
          end else begin
            ptr_d = ptr_inc;
          end
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          mem_we = 1'b1;
          if (ptr_last) begin
            ptr_d   = '0;
            angle_d = '0;
            state_d = StWait;
          end else begin
            ptr_d = ptr_inc;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      ptr_q   <= '0;
      angle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      angle_q <= angle_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid    = (state_q == StDrain);
  assign bus.out_addr     = bus.out_valid ? ptr_q : '0;
  assign bus.out_val      = bus.out_valid ? mem_rdata : '0;
  assign bus.line_done    = bus.out_valid & bus.out_ready & ptr_last;
  assign busy             = (state_q == StClear);
  assign err_kick_overrun = err_q;

endmodule

// File: tb/tb_nabp_pe_accumulator.sv
// Bench for nabp_pe_accumulator: two instances (10-bit and 8-bit accumulators) share
// one stimulus; a transaction-level model predicts each drained line.
module tb_nabp_pe_accumulator;

  localparam int unsigned kSize   = 4;
  localparam int unsigned kAngles = 2;

  typedef struct {
    int addr;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic kick = 1'b0;
  logic tap_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] tap = '0;
  logic busy_a, err_a, busy_b, err_b;

  always #5 clk = ~clk;

  nabp_pe_accumulator_if #(.pDataLength(8), .pAccuLength(10), .pPtrLength(2)) bus_a ();
  nabp_pe_accumulator_if #(.pDataLength(8), .pAccuLength(8), .pPtrLength(2))  bus_b ();

  assign bus_a.sw_pe_kick = kick;
  assign bus_a.tap_valid  = tap_valid;
  assign bus_a.tap        = tap;
  assign bus_a.out_ready  = out_ready;
  assign bus_b.sw_pe_kick = kick;
  assign bus_b.tap_valid  = tap_valid;
  assign bus_b.tap        = tap;
  assign bus_b.out_ready  = out_ready;

  nabp_pe_accumulator #(
    .pDataLength(8), .pAccuLength(10), .pSize(kSize), .pNoOfAngles(kAngles),
    .pPtrLength(2), .pAngleLength(8)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .err_kick_overrun(err_a)
  );

  nabp_pe_accumulator #(
    .pDataLength(8), .pAccuLength(8), .pSize(kSize), .pNoOfAngles(kAngles),
    .pPtrLength(2), .pAngleLength(8)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .err_kick_overrun(err_b)
  );

  exp_t q[2][$];
  int   acc[2][kSize];
  int   pushed[2][kSize];
  int   alen[2] = '{10, 8};
  bit   exp_busy = 1'b1;
  bit   exp_err = 1'b0;
  bit   err_pending = 1'b0;
  bit   drain_pending = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int a, input int t, input int len);
    int s, hi, lo;
    s  = a + t;
    hi = (1 << (len - 1)) - 1;
    lo = -(1 << (len - 1));
    return (s > hi) ? hi : ((s < lo) ? lo : s);
  endfunction

  task automatic check_port(input int d, input logic busy, input logic err, input logic valid,
                            input int addr, input int val, input logic ld);
    string s;
    exp_t  e;
    s = (d == 0) ? "_a" : "_b";
    chk({"busy", s}, int'(busy), int'(exp_busy));
    chk({"err_kick_overrun", s}, int'(err), int'(exp_err));
    chk({"out_valid", s}, int'(valid), int'(q[d].size() > 0));
    if (q[d].size() > 0) begin
      if (valid) begin
        chk({"out_addr", s}, addr, q[d][0].addr);
        chk({"out_val", s}, val, q[d][0].val);
      end
      chk({"line_done", s}, int'(ld), int'(out_ready && q[d].size() == 1));
      if (out_ready) e = q[d].pop_front();
    end else begin
      chk({"out_val_idle", s}, val, 0);
      chk({"line_done_idle", s}, int'(ld), 0);
    end
  endtask

  always @(negedge clk) begin
    check_port(0, busy_a, err_a, bus_a.out_valid, int'(bus_a.out_addr), int'(bus_a.out_val),
               bus_a.line_done);
    check_port(1, busy_b, err_b, bus_b.out_valid, int'(bus_b.out_addr), int'(bus_b.out_val),
               bus_b.line_done);
  end

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // One clock of stimulus; effects of the previous cycle become visible to the model here.
  task automatic drive(input bit k, input bit v, input int t, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    if (err_pending) begin
      exp_err     = 1'b1;
      err_pending = 1'b0;
    end
    if (drain_pending) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < kSize; i++) begin
          e.addr = i;
          e.val  = acc[d][i];
          q[d].push_back(e);
          pushed[d][i] = acc[d][i];
          acc[d][i]    = 0;
        end
      end
      drain_pending = 1'b0;
    end
    kick      = k;
    tap_valid = v;
    tap       = 8'(t);
    out_ready = r;
  endtask

  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) begin
      @(posedge clk);
      #3;
    end
    reset         = 1'b1;
    exp_busy      = 1'b1;
    exp_err       = 1'b0;
    err_pending   = 1'b0;
    drain_pending = 1'b0;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      for (int i = 0; i < kSize; i++) acc[d][i] = 0;
    end
    kick      = 1'b0;
    tap_valid = 1'b0;
    #1;
    chk("busy_on_reset", int'(busy_a), 1);
    chk("err_on_reset", int'(err_a), 0);
    chk("out_valid_on_reset", int'(bus_a.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (kSize) @(posedge clk);
    #1;
    exp_busy = 1'b0;
  endtask

  task automatic run_pass(input int taps[kSize], input bit last, input int ovr_after,
                          input int abort_after, input bit rnd);
    if (rnd) repeat ($urandom_range(0, 2)) drive(0, 1, rnd8(), 1'($urandom_range(0, 1)));
    // A tap presented alongside the kick must not be accumulated.
    drive(1, 1'($urandom_range(0, 1)), rnd8(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < kSize; i++) begin
      if (i == abort_after) return;
      if (rnd) repeat ($urandom_range(0, 2)) drive(0, 0, rnd8(), 1'($urandom_range(0, 1)));
      drive(0, 1, taps[i], 1'($urandom_range(0, 1)));
      for (int d = 0; d < 2; d++) acc[d][i] = sat(acc[d][i], taps[i], alen[d]);
      if (i == ovr_after && i < kSize - 1) begin
        drive(1, 0, rnd8(), 1'($urandom_range(0, 1)));
        err_pending = 1'b1;
      end
    end
    if (last) drain_pending = 1'b1;
  endtask

  // mode 0: always ready, 1: random ready plus stray kicks, 2: fixed backpressure pattern
  task automatic drain(input int mode);
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int n;
    bit r, k;
    n = 0;
    do begin
      r = (mode == 0) ? 1'b1 : (mode == 2) ? ((n < 7) ? 1'(pat[n]) : 1'b1)
                                           : 1'($urandom_range(0, 1));
      k = (mode == 1) && ($urandom_range(0, 7) == 0);
      drive(k, 1'($urandom_range(0, 1)), rnd8(), r);
      if (k) err_pending = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end while ((q[0].size() > 0 || q[1].size() > 0) && n < 60);
    if (q[0].size() > 0 || q[1].size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pixels pending, expected 0", q[0].size());
      q[0].delete();
      q[1].delete();
    end
  endtask

  task automatic run_line(input int t0[kSize], input int t1[kSize], input int ovr,
                          input int mode, input bit rnd);
    run_pass(t0, 1'b0, ovr, -1, rnd);
    run_pass(t1, 1'b1, -1, -1, rnd);
    drain(mode);
  endtask

  initial begin
    int ta[kSize], tb[kSize];

    // 1: reset release, CLEAR lasts kSize cycles
    do_reset(1'b0);

    // 2: two angle passes, then a second line proving clear-on-read
    run_line('{1, 2, 3, 4}, '{10, 20, 30, 40}, -1, 0, 1'b0);
    for (int i = 0; i < kSize; i++) chk("line1_sum", pushed[0][i], 11 * (i + 1));
    run_line('{1, 1, 1, 1}, '{1, 1, 1, 1}, -1, 0, 1'b0);
    for (int i = 0; i < kSize; i++) chk("line2_sum", pushed[0][i], 2);

    // 3: saturation on the 8-bit instance, headroom on the 10-bit one
    run_line('{127, 127, -128, -128}, '{127, 127, -128, -128}, -1, 0, 1'b0);
    chk("sat_hi_b", pushed[1][0], 127);
    chk("sat_lo_b", pushed[1][3], -128);
    chk("nosat_hi_a", pushed[0][1], 254);
    chk("nosat_lo_a", pushed[0][2], -256);

    // 4: backpressure
    run_line('{3, -7, 9, 100}, '{1, 2, 3, 4}, -1, 2, 1'b0);
    chk("bp_sum3", pushed[0][3], 104);

    // 5: kick overrun after the second tap of the first pass
    run_line('{1, 2, 3, 4}, '{10, 20, 30, 40}, 1, 0, 1'b0);
    for (int i = 0; i < kSize; i++) chk("ovr_sum", pushed[0][i], 11 * (i + 1));

    // 6: asynchronous reset during pass 2, then a fresh line
    for (int i = 0; i < kSize; i++) ta[i] = rnd8();
    run_pass(ta, 1'b0, -1, -1, 1'b0);
    run_pass(ta, 1'b0, -1, 2, 1'b0);
    do_reset(1'b1);
    run_line('{5, 5, 5, 5}, '{5, 5, 5, 5}, -1, 0, 1'b0);
    for (int i = 0; i < kSize; i++) chk("post_reset_sum", pushed[0][i], 10);

    // Randomized lines: gaps, stray taps, random ready and overrun kicks
    for (int l = 0; l < 12; l++) begin
      for (int i = 0; i < kSize; i++) begin
        ta[i] = rnd8();
        tb[i] = rnd8();
      end
      run_line(ta, tb, int'($urandom_range(0, 5)), 1, 1'b1);
    end

    repeat (3) drive(0, 0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
